// File: rtl/j_ldarb32_pkg.sv
// Shared Jerry definitions for the holding-register load arbiter.
// Widths, requester limits, FSM state encoding and index type.
`timescale 1ns/1ps
package j_ldarb32_pkg;

    localparam int LDARB_W      = 32;
    localparam int LDARB_MAXREQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } ldarb_st_e;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/j_ldarb32_rrpick.sv
// j_rrpick: combinational round-robin picker for j_ldarb32.
// Ports: req_i request vector, ptr_i last winner, prio0_i fixed
// priority for requester 0; vld_o any winner, idx_o winner index.
`timescale 1ns/1ps
module j_rrpick
    import j_ldarb32_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    input  logic            prio0_i,
    output logic            vld_o,
    output logic [1:0]      idx_o
);

    logic     found;
    req_idx_t win;
    int       c;

    // Scan from ptr+1 around the ring; with prio0 set, index 0
    // is taken out of the ring and overrides everything.
    always_comb begin
        found = 1'b0;
        win   = '0;
        c     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[c] && !(prio0_i && c == 0)) begin
                found = 1'b1;
                win   = req_idx_t'(c);
            end
        end
        if (prio0_i && req_i[0]) begin
            found = 1'b1;
            win   = '0;
        end
    end

    assign vld_o = found;
    assign idx_o = win;

endmodule

// File: rtl/j_ldarb32.sv
// j_ldarb32: arbiter/load sequencer for one shared 32-bit holding reg.
// Ports: sys_clk, reset (sync, active high), req/req_d per requester;
// ld/ld_d drive the register, ack pulse, gnt_id last winner, busy.
// Macro J_LDARB_PRIO0_EN: requester 0 gets fixed highest priority.
`timescale 1ns/1ps
module j_ldarb32
    import j_ldarb32_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int HOLD_CYC = 2
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [0:NREQ*LDARB_W-1] req_d,
    output logic                    ld,
    output logic [0:LDARB_W-1]      ld_d,
    output logic [NREQ-1:0]         ack,
    output logic [1:0]              gnt_id,
    output logic                    busy
);

`ifdef J_LDARB_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    ldarb_st_e          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    req_idx_t           ptr_q, ptr_d;
    req_idx_t           gnt_q, gnt_d;
    logic [0:LDARB_W-1] dat_q, dat_d;
    logic               ldstb_q, ldstb_d;
    logic               busy_q, busy_d;
    logic [NREQ-1:0]    ack_q, ack_d;

    logic               pick_vld;
    req_idx_t           pick_idx;

    j_rrpick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .prio0_i (PRIO0),
        .vld_o   (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dat_d   = dat_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = LOAD;
                    gnt_d   = pick_idx;
                    dat_d   = req_d[int'(pick_idx)*LDARB_W +: LDARB_W];
                    // Grants to a fixed-priority 0 leave the ring alone.
                    if (!(PRIO0 && pick_idx == 2'd0)) begin
                        ptr_d = pick_idx;
                    end
                end
            end
            LOAD: begin
                state_d       = HOLD;
                cnt_d         = 4'(HOLD_CYC - 1);
                // Registered, so it lands in the first HOLD cycle.
                ack_d[gnt_q]  = 1'b1;
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ldstb_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= req_idx_t'(NREQ - 1);
            gnt_q   <= '0;
            dat_q   <= '0;
            ldstb_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dat_q   <= dat_d;
            ldstb_q <= ldstb_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign ld     = ldstb_q;
    assign ld_d   = dat_q;
    assign ack    = ack_q;
    assign gnt_id = gnt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_j_ldarb32.sv
// Directed bench for j_ldarb32: three instances (HOLD_CYC 2, 1, 15).
// Hand-computed expectations for load timing, order, ack and reset.
`timescale 1ns/1ps
module tb_j_ldarb32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req0, req1, req2;
    logic [0:95] rd0, rd1, rd2;
    logic        ld0, ld1, ld2;
    logic [0:31] ldd0, ldd1, ldd2;
    logic [2:0]  ack0, ack1, ack2;
    logic [1:0]  gnt0, gnt1, gnt2;
    logic        busy0, busy1, busy2;

    j_ldarb32 #(.NREQ(3), .HOLD_CYC(2)) u0 (
        .sys_clk(clk), .reset(reset), .req(req0), .req_d(rd0),
        .ld(ld0), .ld_d(ldd0), .ack(ack0), .gnt_id(gnt0), .busy(busy0));
    j_ldarb32 #(.NREQ(3), .HOLD_CYC(1)) u1 (
        .sys_clk(clk), .reset(reset), .req(req1), .req_d(rd1),
        .ld(ld1), .ld_d(ldd1), .ack(ack1), .gnt_id(gnt1), .busy(busy1));
    j_ldarb32 #(.NREQ(3), .HOLD_CYC(15)) u2 (
        .sys_clk(clk), .reset(reset), .req(req2), .req_d(rd2),
        .ld(ld2), .ld_d(ldd2), .ack(ack2), .gnt_id(gnt2), .busy(busy2));

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] exp_d [3];
    logic [1:0]  exp_g [3];
    int          nld, nack, nbusy, bad, first_ack;
    logic        pend;

    initial begin
        req0 = '0; req1 = '0; req2 = '0;
        rd0 = '0; rd1 = '0; rd2 = '0;
        exp_d[0] = 32'hA0A0_0000;
        exp_d[1] = 32'hB1B1_1111;
        exp_d[2] = 32'hC2C2_2222;
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2;

        do_reset();
        check("rst_ld", 32'(ld0), 32'd0);
        check("rst_ldd", ldd0, 32'd0);
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_gnt", 32'(gnt0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);

        // single requester
        rd0[32 +: 32] = 32'hDEADBEEF;
        req0 = 3'b010;
        tick();
        check("s_ld", 32'(ld0), 32'd1);
        check("s_ldd", ldd0, 32'hDEADBEEF);
        check("s_busy1", 32'(busy0), 32'd1);
        tick();
        check("s_ack", 32'(ack0), 32'(3'b010));
        check("s_ld_off", 32'(ld0), 32'd0);
        req0 = 3'b000;
        tick();
        check("s_ack_off", 32'(ack0), 32'd0);
        check("s_busy3", 32'(busy0), 32'd1);
        tick();
        check("s_busy4", 32'(busy0), 32'd0);
        check("s_gnt", 32'(gnt0), 32'd1);

        // contention, fresh pointer
        do_reset();
        rd0[0 +: 32]  = exp_d[0];
        rd0[32 +: 32] = exp_d[1];
        rd0[64 +: 32] = exp_d[2];
        req0 = 3'b111;
        nld = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1 || c == 5 || c == 9) begin
                check($sformatf("c_ld%0d", c), 32'(ld0), 32'd1);
                check($sformatf("c_gnt%0d", c), 32'(gnt0),
                      32'(exp_g[(c-1)/4]));
                check($sformatf("c_ldd%0d", c), ldd0, exp_d[(c-1)/4]);
            end
            if (ld0) nld++;
            req0 = req0 & ~ack0;
        end
        check("c_nld", nld, 3);
        check("c_req_left", 32'(req0), 32'd0);

        // one-cycle request pulse
        do_reset();
        rd0[0 +: 32] = 32'h1234_5678;
        req0 = 3'b001;
        tick();
        req0 = 3'b000;
        check("p_ld", 32'(ld0), 32'd1);
        check("p_ldd", ldd0, 32'h1234_5678);
        tick();
        check("p_ack", 32'(ack0), 32'(3'b001));
        nld = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ld0) nld++;
        end
        check("p_noload", nld, 0);

        // reset in the ack cycle
        do_reset();
        rd0[32 +: 32] = 32'h0BAD_F00D;
        req0 = 3'b010;
        tick();
        check("r_ld", 32'(ld0), 32'd1);
        tick();
        check("r_ack_pre", 32'(ack0), 32'(3'b010));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_ld0", 32'(ld0), 32'd0);
        check("r_ldd0", ldd0, 32'd0);
        check("r_ack0", 32'(ack0), 32'd0);
        check("r_gnt0", 32'(gnt0), 32'd0);
        check("r_busy0", 32'(busy0), 32'd0);
        tick();
        check("r_reld", 32'(ld0), 32'd1);
        check("r_regnt", 32'(gnt0), 32'd1);
        tick();
        check("r_reack", 32'(ack0), 32'(3'b010));
        req0 = 3'b000;

        // back-to-back, HOLD_CYC=1
        do_reset();
        rd1[64 +: 32] = 32'h5555_AAAA;
        req1 = 3'b100;
        bad = 0;
        pend = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("b_ld%0d", c), 32'(ld1),
                  32'((c % 3) == 1));
            if (ld1) begin
                if (pend) bad++;
                pend = 1'b1;
            end
            if (ack1[2]) begin
                pend = 1'b0;
                req1 = 3'b000;
            end else if (req1 == 3'b000) begin
                req1 = 3'b100;
            end
        end
        check("b_noack_gap", bad, 0);
        check("b_gnt", 32'(gnt1), 32'd2);
        req1 = 3'b000;

        // HOLD_CYC=15
        do_reset();
        req2 = 3'b001;
        nld = 0; nack = 0; nbusy = 0; first_ack = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (busy2) nbusy++;
            if (ld2) nld++;
            if (ack2 != 3'b000) begin
                nack++;
                if (first_ack == 0) first_ack = c;
                req2 = 3'b000;
            end
        end
        check("h_busy", nbusy, 16);
        check("h_nld", nld, 1);
        check("h_nack", nack, 1);
        check("h_ack_t", first_ack, 2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
